// File: rtl/umi_fifo_arb.sv
// umi_fifo_arb: N-channel buffered UMI merge stage.
// Each input channel owns a DEPTH-entry FIFO; a round-robin arbiter pops one
// channel per load slot into a single registered UMI output. A free-running
// 16-bit LFSR can inject pseudo-random load stalls (chaos mode) to shake out
// downstream assumptions about back-to-back traffic.
//
// Handshake semantics (all UMI ports): a word transfers on a rising edge where
// valid and ready are both high. A producer never withdraws or changes a word
// while valid is high and ready is low. umi_in_ready depends only on registered
// FIFO state and reset, never on umi_in_valid, so there is no combinational
// path from any input valid to any ready.
module umi_fifo_arb #(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  localparam int CHW  = (N > 1) ? $clog2(N) : 1,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chaosmode,
  input  logic [N-1:0]      umi_in_valid,
  input  logic [N*CW-1:0]   umi_in_cmd,
  input  logic [N*AW-1:0]   umi_in_dstaddr,
  input  logic [N*AW-1:0]   umi_in_srcaddr,
  input  logic [N*DW-1:0]   umi_in_data,
  output logic [N-1:0]      umi_in_ready,
  output logic              umi_out_valid,
  output logic [CW-1:0]     umi_out_cmd,
  output logic [AW-1:0]     umi_out_dstaddr,
  output logic [AW-1:0]     umi_out_srcaddr,
  output logic [DW-1:0]     umi_out_data,
  output logic [CHW-1:0]    umi_out_chan,
  input  logic              umi_out_ready,
  output logic [N-1:0]      fifo_full,
  output logic [N-1:0]      fifo_empty,
  output logic [N*PW-1:0]   fifo_count
);

  // Pointer width and the packed payload width {cmd, dstaddr, srcaddr, data}.
  localparam int PTRW = $clog2(DEPTH);
  localparam int PLW  = CW + 2 * AW + DW;

  // Per-channel payload views and handshake strobes.
  logic [PLW-1:0] in_pl   [N];
  logic [PLW-1:0] head_pl [N];
  logic [N-1:0]   push;
  logic [N-1:0]   pop;

  // Arbiter and output-register state.
  logic [CHW-1:0] last_grant;
  logic [CHW-1:0] grant;
  logic [CHW-1:0] idx;
  logic           found;
  logic           load_slot;
  logic           stall;
  logic           load_en;
  logic [PLW-1:0] out_pl_q;
  logic [15:0]    lfsr_q;

  // Ready is purely a function of the registered full flag; held low in reset.
  assign umi_in_ready = ~fifo_full & {N{~reset}};

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [PLW-1:0]  mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PW-1:0]   cnt;
    logic [PW-1:0]   cnt_nxt;
    logic            full_q;
    logic            empty_q;

    assign in_pl[i] = {umi_in_cmd[i*CW +: CW],
                       umi_in_dstaddr[i*AW +: AW],
                       umi_in_srcaddr[i*AW +: AW],
                       umi_in_data[i*DW +: DW]};

    assign push[i]  = umi_in_valid[i] & umi_in_ready[i];
    assign head_pl[i] = mem[rd_ptr];

    assign fifo_count[i*PW +: PW] = cnt;
    assign fifo_full[i]  = full_q;
    assign fifo_empty[i] = empty_q;

    // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
    always_comb begin
      cnt_nxt = cnt;
      if (push[i] && !pop[i]) begin
        cnt_nxt = cnt + PW'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_nxt = cnt - PW'(1);
      end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        if (push[i]) begin
          wr_ptr <= wr_ptr + PTRW'(1);
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + PTRW'(1);
        end
        cnt     <= cnt_nxt;
        full_q  <= (cnt_nxt == PW'(DEPTH));
        empty_q <= (cnt_nxt == '0);
      end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem[wr_ptr] <= in_pl[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chaos LFSR: Fibonacci, taps 16,14,13,11, free-running from reset.
  // ---------------------------------------------------------------------------

  // Advance the LFSR every cycle regardless of chaosmode.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------

  // The output register may take a new word when empty or being drained now;
  // chaos mode can veto that slot, but never a word already presented.
  assign load_slot = ~umi_out_valid | umi_out_ready;
  assign stall     = chaosmode & ~lfsr_q[0];
  assign load_en   = load_slot & ~stall;

  // Round-robin search starting just after the previous grant, wrapping at N.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = CHW'((int'(last_grant) + k) % N);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // One-hot pop strobe for the granted channel in a live load slot.
  always_comb begin
    pop = '0;
    if (load_en && found) begin
      pop[grant] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------

  // Load on a granted slot, drop valid on an empty slot or a vetoed drain,
  // otherwise hold the presented word untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      umi_out_valid <= 1'b0;
      out_pl_q      <= '0;
      umi_out_chan  <= '0;
      last_grant    <= CHW'(N - 1);
    end else if (load_en) begin
      if (found) begin
        umi_out_valid <= 1'b1;
        out_pl_q      <= head_pl[grant];
        umi_out_chan  <= grant;
        last_grant    <= grant;
      end else begin
        umi_out_valid <= 1'b0;
      end
    end else if (umi_out_valid && umi_out_ready) begin
      umi_out_valid <= 1'b0;
    end
  end

  assign umi_out_data    = out_pl_q[DW-1:0];
  assign umi_out_srcaddr = out_pl_q[DW +: AW];
  assign umi_out_dstaddr = out_pl_q[DW+AW +: AW];
  assign umi_out_cmd     = out_pl_q[DW+2*AW +: CW];

endmodule

// File: tb/tb_umi_fifo_arb.sv
// tb_umi_fifo_arb: self-checking bench for umi_fifo_arb (N=4, DEPTH=8).
// Inputs change 1ns after the rising edge; a negedge monitor keeps per-channel
// expected queues of accepted words and checks every output handshake,
// occupancy, flags and output stability under backpressure.
module tb_umi_fifo_arb;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int CW    = 32;
  localparam int CHW   = 2;
  localparam int PW    = 4;
  localparam int PLW   = CW + 2 * AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              chaosmode;
  logic [N-1:0]      in_valid;
  logic [N*CW-1:0]   in_cmd;
  logic [N*AW-1:0]   in_dst;
  logic [N*AW-1:0]   in_src;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [CW-1:0]     out_cmd;
  logic [AW-1:0]     out_dst;
  logic [AW-1:0]     out_src;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_chan;
  logic              out_ready;
  logic [N-1:0]      fifo_full;
  logic [N-1:0]      fifo_empty;
  logic [N*PW-1:0]   fifo_count;

  umi_fifo_arb #(.N(N), .DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .chaosmode       (chaosmode),
    .umi_in_valid    (in_valid),
    .umi_in_cmd      (in_cmd),
    .umi_in_dstaddr  (in_dst),
    .umi_in_srcaddr  (in_src),
    .umi_in_data     (in_data),
    .umi_in_ready    (in_ready),
    .umi_out_valid   (out_valid),
    .umi_out_cmd     (out_cmd),
    .umi_out_dstaddr (out_dst),
    .umi_out_srcaddr (out_src),
    .umi_out_data    (out_data),
    .umi_out_chan    (out_chan),
    .umi_out_ready   (out_ready),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_count      (fifo_count)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int seq    = 0;
  bit mon_en = 1'b0;

  logic [PLW-1:0] exp_q [N][$];
  bit             hold_pending = 1'b0;
  logic [PLW-1:0] held_pl;
  logic [CHW-1:0] held_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pl(input string name, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PLW-1:0] in_word(input int ch);
    return {in_cmd[ch*CW +: CW], in_dst[ch*AW +: AW], in_src[ch*AW +: AW], in_data[ch*DW +: DW]};
  endfunction

  function automatic logic [PLW-1:0] out_word();
    return {out_cmd, out_dst, out_src, out_data};
  endfunction

  function automatic logic [PW-1:0] cnt_of(input int ch);
    return fifo_count[ch*PW +: PW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive channel ch; a fresh tagged random payload each time valid is set.
  task automatic drive(input int ch, input bit v);
    in_valid[ch] = v;
    if (v) begin
      seq++;
      in_cmd[ch*CW +: CW]  = {8'(ch), 24'(seq)};
      in_dst[ch*AW +: AW]  = $urandom;
      in_src[ch*AW +: AW]  = $urandom;
      in_data[ch*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  task automatic idle_inputs();
    for (int ch = 0; ch < N; ch++) drive(ch, 1'b0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Empty everything with ready=1; an expired budget counts as a failure.
  task automatic drain(input string name);
    int left;
    int budget;
    idle_inputs();
    out_ready = 1'b1;
    budget = 0;
    left = 1;
    while (left != 0 && budget < 400) begin
      step();
      budget++;
      left = 32'(out_valid);
      for (int ch = 0; ch < N; ch++) left += exp_q[ch].size();
    end
    chk(name, 32'(left), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Model view: every accepted word is either in its channel FIFO or sitting
  // in the output register, and leaves in per-channel arrival order.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < N; ch++) begin
        int occ;
        occ = exp_q[ch].size() - ((out_valid && out_chan == CHW'(ch)) ? 1 : 0);
        chk("fifo_count", 32'(cnt_of(ch)), 32'(occ));
        chk("fifo_full", 32'(fifo_full[ch]), (occ == DEPTH) ? 1 : 0);
        chk("fifo_empty", 32'(fifo_empty[ch]), (occ == 0) ? 1 : 0);
      end
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk_pl("hold_data", out_word(), held_pl);
        chk("hold_chan", 32'(out_chan), 32'(held_ch));
      end
      hold_pending = 1'b0;
      if (reset) begin
        for (int ch = 0; ch < N; ch++) exp_q[ch].delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q[out_chan].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: chan %0d word %0h with nothing queued", out_chan, out_word());
          end else begin
            chk_pl("out_data", out_word(), exp_q[out_chan].pop_front());
          end
        end else if (out_valid) begin
          hold_pending = 1'b1;
          held_pl = out_word();
          held_ch = out_chan;
        end
        for (int ch = 0; ch < N; ch++) begin
          if (in_valid[ch] && in_ready[ch]) exp_q[ch].push_back(in_word(ch));
        end
      end
    end
  end

  // ---------------- arbitration vector table ----------------
  // cnt: words preloaded per channel {c3,c2,c1,c0}; seq: expected output
  // channels {s7..s0}, first grant in s0, starting from channel 0 after reset.
  typedef struct packed {
    logic [3:0][1:0] cnt;
    logic [3:0]      len;
    logic [7:0][1:0] seq;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [PLW-1:0] w0;
    int idle;

    vecs[0] = '{cnt: {2'd2, 2'd2, 2'd2, 2'd2}, len: 4'd8, seq: {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{cnt: {2'd0, 2'd1, 2'd0, 2'd3}, len: 4'd4, seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[2] = '{cnt: {2'd2, 2'd0, 2'd1, 2'd0}, len: 4'd3, seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1}};
    vecs[3] = '{cnt: {2'd0, 2'd0, 2'd0, 2'd1}, len: 4'd1, seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[4] = '{cnt: {2'd3, 2'd0, 2'd0, 2'd0}, len: 4'd3, seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3}};
    vecs[5] = '{cnt: {2'd2, 2'd3, 2'd2, 2'd1}, len: 4'd8, seq: {2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0}};

    reset = 1'b1;
    chaosmode = 1'b0;
    out_ready = 1'b0;
    in_valid = '0;
    in_cmd = '0;
    in_dst = '0;
    in_src = '0;
    in_data = '0;
    step();
    step();

    // Reset state, sampled while reset is still high.
    chk("rst_out_valid", 32'(out_valid), 0);
    chk_pl("rst_payload", out_word(), '0);
    chk("rst_out_chan", 32'(out_chan), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(fifo_empty), 32'hF);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    mon_en = 1'b1;
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'hF);

    // Minimum latency on channel 2: pushed at E0, presented after E1.
    out_ready = 1'b1;
    drive(2, 1'b1);
    w0 = in_word(2);
    step();
    chk("lat_not_yet", 32'(out_valid), 0);
    drive(2, 1'b1);
    step();
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_chan", 32'(out_chan), 2);
    chk_pl("lat_word", out_word(), w0);
    drive(2, 1'b1);
    step();
    drive(2, 1'b0);
    chk("lat_stream_valid", 32'(out_valid), 1);
    chk("lat_stream_chan", 32'(out_chan), 2);
    drain("lat_drain");

    // Table: preload with ready low, then release and check grant order with
    // one word per cycle and nothing left afterwards.
    for (int t = 0; t < 6; t++) begin
      reset_dut();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < N; ch++) drive(ch, int'(vecs[t].cnt[ch]) > k);
        step();
      end
      idle_inputs();
      step();
      out_ready = 1'b1;
      for (int j = 0; j < int'(vecs[t].len); j++) begin
        chk($sformatf("tbl%0d_valid%0d", t, j), 32'(out_valid), 1);
        chk($sformatf("tbl%0d_chan%0d", t, j), 32'(out_chan), 32'(vecs[t].seq[j]));
        step();
      end
      chk($sformatf("tbl%0d_done", t), 32'(out_valid), 0);
    end

    // Backpressure: 9 words on channel 1 with ready low, 10th refused.
    reset_dut();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(1, 1'b1);
      step();
      if (k == 7) begin
        chk("bp_count7", 32'(cnt_of(1)), 7);
        chk("bp_ready7", 32'(in_ready[1]), 1);
      end
    end
    chk("bp_count8", 32'(cnt_of(1)), 8);
    chk("bp_full", 32'(fifo_full[1]), 1);
    chk("bp_in_ready", 32'(in_ready[1]), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_chan", 32'(out_chan), 1);
    drive(1, 1'b1);
    step();
    chk("bp_refused", 32'(cnt_of(1)), 8);
    drain("bp_drain");

    // Reset with 5 words buffered: nothing emitted afterwards, channel 0 first.
    reset_dut();
    out_ready = 1'b0;
    drive(1, 1'b1); drive(3, 1'b1); step();
    drive(1, 1'b1); drive(3, 1'b1); step();
    drive(1, 1'b0); drive(3, 1'b1); step();
    idle_inputs();
    step();
    reset_dut();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'hF);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_rst_quiet", 32'(out_valid), 0);
    end
    drive(0, 1'b1);
    drive(2, 1'b1);
    step();
    idle_inputs();
    step();
    chk("mid_rst_grant_valid", 32'(out_valid), 1);
    chk("mid_rst_grant_chan", 32'(out_chan), 0);
    drain("mid_rst_drain");

    // Simultaneous push and pop on channel 0 at occupancy 4.
    reset_dut();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1);
      step();
    end
    idle_inputs();
    step();
    chk("pp_count_init", 32'(cnt_of(0)), 4);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1);
      step();
      chk("pp_count_hold", 32'(cnt_of(0)), 4);
    end
    drain("pp_drain");

    // Chaos stalls with saturated inputs, then full rate once chaos is off.
    reset_dut();
    chaosmode = 1'b1;
    out_ready = 1'b1;
    idle = 0;
    for (int k = 0; k < 64; k++) begin
      for (int ch = 0; ch < N; ch++) drive(ch, 1'b1);
      step();
      if (k >= 4 && !out_valid) idle++;
    end
    chk("chaos_some_stalls", 32'(idle > 0 && idle < 60), 1);
    chaosmode = 1'b0;
    idle = 0;
    for (int k = 0; k < 32; k++) begin
      for (int ch = 0; ch < N; ch++) drive(ch, 1'b1);
      step();
      if (!out_valid) idle++;
    end
    chk("full_rate_no_idle", 32'(idle), 0);
    drain("chaos_drain");

    // Random traffic, random ready, chaos for the first half, one reset inside.
    reset_dut();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      chaosmode = (cyc < 500);
      reset = (cyc == 300);
      out_ready = ($urandom_range(0, 99) < (chaosmode ? 50 : 70));
      for (int ch = 0; ch < N; ch++) drive(ch, $urandom_range(0, 99) < 40);
      step();
    end
    reset = 1'b0;
    chaosmode = 1'b0;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
